// File: rtl/mini_cpu_core.sv
// mini_cpu_core
// Single-step 8-bit processor core. Each accepted start pulse runs one
// instruction through FETCH -> LOAD -> EXEC. With FREE_RUN set, the core keeps
// going until it reaches a HLT instruction. The 16-bit instructions come from
// an external synchronous ROM that has one cycle of read latency.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   start      one-cycle step pulse, only honoured while IDLE
//   imem_data  ROM read data, valid one cycle after imem_addr
//   imem_addr  ROM address, combinationally equal to pc
//   pc         program counter
//   ir         instruction register
//   rf_data    packed register file {R4,R3,R2,R1,R0}
//   busy       high in FETCH/LOAD/EXEC
//   halted     high in HALT
module mini_cpu_core #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter bit         FREE_RUN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] imem_data,
    output logic [7:0]  imem_addr,
    output logic [7:0]  pc,
    output logic [15:0] ir,
    output logic [39:0] rf_data,
    output logic        busy,
    output logic        halted
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] NUM_REGS = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_HALT
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0] regs [0:4];

    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [7:0] imm;

    logic [7:0] rd_val;
    logic [7:0] rs_val;
    logic [7:0] rt_val;

    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] pc_next;
    logic       is_hlt;

    assign op  = ir[15:12];
    assign rd  = ir[11:9];
    assign rs  = ir[8:6];
    assign rt  = ir[5:3];
    assign imm = ir[7:0];

    assign imem_addr = pc;
    assign rf_data   = {regs[4], regs[3], regs[2], regs[1], regs[0]};

    // Only R0..R4 exist; the three spare encodings read back as zero.
    always_comb begin
        rd_val = 8'h00;
        rs_val = 8'h00;
        rt_val = 8'h00;
        if (rd < NUM_REGS) rd_val = regs[rd];
        if (rs < NUM_REGS) rs_val = regs[rs];
        if (rt < NUM_REGS) rt_val = regs[rt];
    end

    // Instruction decode and ALU. Results are applied only on the EXEC edge,
    // so all operands here are the values from before that edge.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = 8'h00;
        pc_next = pc + 8'd1;
        is_hlt  = 1'b0;
        case (op)
            OP_LDI: begin
                wr_en   = 1'b1;
                wr_data = imm;
            end
            OP_ADD: begin
                wr_en   = 1'b1;
                wr_data = rs_val + rt_val;
            end
            OP_SUB: begin
                wr_en   = 1'b1;
                wr_data = rs_val - rt_val;
            end
            OP_AND: begin
                wr_en   = 1'b1;
                wr_data = rs_val & rt_val;
            end
            OP_OR: begin
                wr_en   = 1'b1;
                wr_data = rs_val | rt_val;
            end
            OP_XOR: begin
                wr_en   = 1'b1;
                wr_data = rs_val ^ rt_val;
            end
            OP_MOV: begin
                wr_en   = 1'b1;
                wr_data = rs_val;
            end
            OP_JMP: begin
                pc_next = imm;
            end
            OP_JZ: begin
                if (rd_val == 8'h00) pc_next = imm;
            end
            OP_ADDI: begin
                wr_en   = 1'b1;
                wr_data = rd_val + imm;
            end
            OP_HLT: begin
                pc_next = pc;
                is_hlt  = 1'b1;
            end
            default: begin
                // NOP and the unused opcodes B..E only advance pc.
            end
        endcase
    end

    // Sequencer: next state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        halted     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                busy       = 1'b1;
                state_next = S_LOAD;
            end
            S_LOAD: begin
                busy       = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (is_hlt) begin
                    state_next = S_HALT;
                end else if (FREE_RUN) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Architectural state. Reset takes priority, so an instruction that is in
    // EXEC when rst is sampled never writes pc or the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
            for (int i = 0; i < 5; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            state <= state_next;
            if (state == S_LOAD) begin
                ir <= imem_data;
            end
            if (state == S_EXEC) begin
                pc <= pc_next;
                if (wr_en && (rd < NUM_REGS)) begin
                    regs[rd] <= wr_data;
                end
            end
        end
    end

endmodule
